seq_alu: RTL



---
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arith/logic with registered results, and
// shift/rotate ops that iterate one bit per clock behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH      = 16,
    parameter int COUNT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic             i_is_half,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [15:0]      i_flags_in,
    output logic [WIDTH-1:0] o_out,
    output logic [15:0]      o_flags_out,
    output logic             o_busy,
    output logic             o_done
);
    localparam int H  = WIDTH / 2;
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] HALF_MASK = {{H{1'b0}}, {H{1'b1}}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [3:0] OP_SELB = 4'd1,  OP_ADD = 4'd2,  OP_ADC = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4,  OP_SBB = 4'd5,  OP_AND = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7,  OP_XOR = 4'd8,  OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10, OP_SAR = 4'd11, OP_ROL = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13, OP_RCL = 4'd14, OP_RCR = 4'd15;

    logic [0:0]            r_state;
    logic [WIDTH-1:0]      r_out, r_work;
    logic [15:0]           r_flags_out, r_flags;
    logic                  r_done, r_cf, r_half, r_amsb;
    logic [3:0]            r_op;
    logic [COUNT_BITS-1:0] r_rem;

    logic [WIDTH-1:0] w_in_mask, w_ma, w_mb, w_res, w_r_mask, w_step;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [IW-1:0]    w_imsb, w_rmsb;
    logic [15:0]      w_flg, w_sflg;
    logic             w_cin, w_carry, w_ovf, w_szp, w_arith, w_top, w_low, w_ncf;
    logic             w_is_shift, w_cnt_nz;

    assign w_in_mask  = i_is_half ? HALF_MASK : '1;
    assign w_r_mask   = r_half ? HALF_MASK : '1;
    assign w_imsb     = i_is_half ? IW'(H - 1) : IW'(WIDTH - 1);
    assign w_rmsb     = r_half ? IW'(H - 1) : IW'(WIDTH - 1);
    assign w_ma       = i_a & w_in_mask;
    assign w_mb       = i_b & w_in_mask;
    assign w_cin      = ((i_op == OP_ADC) || (i_op == OP_SBB)) & i_flags_in[0];
    assign w_sum      = {1'b0, w_ma} + {1'b0, w_mb} + {{WIDTH{1'b0}}, w_cin};
    assign w_dif      = {1'b0, w_ma} - {1'b0, w_mb} - {{WIDTH{1'b0}}, w_cin};
    assign w_is_shift = (i_op >= OP_SHL);
    assign w_cnt_nz   = (i_b[COUNT_BITS-1:0] != '0);
    assign w_top      = r_work[w_rmsb];
    assign w_low      = r_work[0];

    // Single-cycle result; shifts with a zero count fall through as a pass of a.
    always_comb begin
        w_res   = w_ma;
        w_flg   = i_flags_in;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_szp   = 1'b0;
        w_arith = 1'b0;
        case (i_op)
            OP_SELB: w_res = w_mb;
            OP_ADD, OP_ADC: begin
                w_res   = w_sum[WIDTH-1:0] & w_in_mask;
                w_carry = i_is_half ? w_sum[H] : w_sum[WIDTH];
                w_ovf   = (w_ma[w_imsb] == w_mb[w_imsb]) && (w_res[w_imsb] != w_ma[w_imsb]);
                w_szp   = 1'b1;
                w_arith = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                w_res   = w_dif[WIDTH-1:0] & w_in_mask;
                w_carry = i_is_half ? w_dif[H] : w_dif[WIDTH];
                w_ovf   = (w_ma[w_imsb] != w_mb[w_imsb]) && (w_res[w_imsb] != w_ma[w_imsb]);
                w_szp   = 1'b1;
                w_arith = 1'b1;
            end
            OP_AND: begin w_res = w_ma & w_mb; w_szp = 1'b1; end
            OP_OR:  begin w_res = w_ma | w_mb; w_szp = 1'b1; end
            OP_XOR: begin w_res = w_ma ^ w_mb; w_szp = 1'b1; end
            default: ;
        endcase
        if (w_szp) begin
            w_flg[0]  = w_carry;
            w_flg[11] = w_ovf;
            w_flg[2]  = ~^w_res[7:0];
            w_flg[6]  = (w_res == '0);
            w_flg[7]  = w_res[w_imsb];
        end
        if (w_arith) w_flg[4] = w_ma[4] ^ w_mb[4] ^ w_res[4];
    end

    // One-bit step of the working register; RCL/RCR carry r_cf as the extra bit.
    always_comb begin
        w_step = r_work >> 1;
        w_ncf  = w_low;
        case (r_op)
            OP_SHL: begin w_step = (r_work << 1) & w_r_mask; w_ncf = w_top; end
            OP_SAR: w_step[w_rmsb] = w_top;
            OP_ROL: begin
                w_step = ((r_work << 1) & w_r_mask) | {{(WIDTH-1){1'b0}}, w_top};
                w_ncf  = w_top;
            end
            OP_ROR: w_step[w_rmsb] = w_low;
            OP_RCL: begin
                w_step = ((r_work << 1) & w_r_mask) | {{(WIDTH-1){1'b0}}, r_cf};
                w_ncf  = w_top;
            end
            OP_RCR: w_step[w_rmsb] = r_cf;
            default: ;
        endcase
        w_sflg    = r_flags;
        w_sflg[0] = w_ncf;
        case (r_op)
            OP_SHL, OP_ROL, OP_RCL: w_sflg[11] = w_step[w_rmsb] ^ w_ncf;
            OP_SHR:                 w_sflg[11] = r_amsb;
            OP_SAR:                 w_sflg[11] = 1'b0;
            default:                w_sflg[11] = w_step[w_rmsb] ^ w_step[w_rmsb - 1'b1];
        endcase
        if ((r_op == OP_SHL) || (r_op == OP_SHR) || (r_op == OP_SAR)) begin
            w_sflg[2] = ~^w_step[7:0];
            w_sflg[6] = (w_step == '0);
            w_sflg[7] = w_step[w_rmsb];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_flags_out <= '0;
            r_done      <= 1'b0;
            r_rem       <= '0;
            r_work      <= '0;
            r_cf        <= 1'b0;
            r_op        <= '0;
            r_half      <= 1'b0;
            r_flags     <= '0;
            r_amsb      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    if (w_is_shift && w_cnt_nz) begin
                        r_state <= S_SHIFT;
                        r_work  <= w_ma;
                        r_cf    <= i_flags_in[0];
                        r_rem   <= i_b[COUNT_BITS-1:0];
                        r_op    <= i_op;
                        r_half  <= i_is_half;
                        r_flags <= i_flags_in;
                        r_amsb  <= w_ma[w_imsb];
                    end else begin
                        r_out       <= w_res;
                        r_flags_out <= w_flg;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    // Final step commits straight to the outputs.
                    if (r_rem == COUNT_BITS'(1)) begin
                        r_out       <= w_step;
                        r_flags_out <= w_sflg;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_work <= w_step;
                        r_cf   <= w_ncf;
                    end
                    r_rem <= r_rem - COUNT_BITS'(1);
                end
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_flags_out = r_flags_out;
    assign o_busy      = (r_state == S_SHIFT);
    assign o_done      = r_done;
endmodule
